// File: rtl/jam_cost_loader.sv
// Cost-table loader for the 8x8 job-assignment core: buffers one frame, runs the core, holds its result.
// Optional JAM_COST_CHECKSUM_EN adds a CHKSUM output summing the accepted entries of the current frame.
module jam_cost_loader #(
  parameter int N      = 8,
  parameter int COST_W = 7,
  parameter int SUM_W  = 10
) (
  input  logic                   CLK,
  input  logic                   RST,
  input  logic                   IN_VALID,
  output logic                   IN_READY,
  input  logic [COST_W-1:0]      IN_DATA,
  input  logic                   IN_LAST,
  output logic                   CORE_RST,
  input  logic [$clog2(N)-1:0]   CORE_W,
  input  logic [$clog2(N)-1:0]   CORE_J,
  output logic [COST_W-1:0]      CORE_COST,
  input  logic [SUM_W-1:0]       CORE_MINCOST,
  input  logic [3:0]             CORE_MATCH,
  input  logic                   CORE_VALID,
  output logic                   RES_VALID,
  input  logic                   RES_ACK,
  output logic [SUM_W-1:0]       RES_COST,
  output logic [3:0]             RES_MATCH,
`ifdef JAM_COST_CHECKSUM_EN
  output logic [COST_W+5:0]      CHKSUM,
`endif
  output logic                   FRAME_ERR
);

  localparam int AW    = $clog2(N*N);
  localparam int DEPTH = N*N;

  localparam logic [1:0] ST_LOAD  = 2'd0;
  localparam logic [1:0] ST_SERVE = 2'd1;
  localparam logic [1:0] ST_HOLD  = 2'd2;

  typedef struct packed {
    logic [SUM_W-1:0] cost;
    logic [3:0]       match;
  } res_t;

  logic [1:0]        state;
  logic [AW-1:0]     wr_cnt;
  logic [COST_W-1:0] buf_q [DEPTH];
  logic              core_rst_q;
  logic              serve_first;
  logic              res_vld_q;
  logic              frame_err_q;
  res_t              res_q;

  logic              accept;
  logic              last_slot;
  logic              core_done;
  logic [AW-1:0]     rd_idx;

  assign IN_READY  = (state == ST_LOAD);
  assign accept    = IN_VALID & IN_READY;
  assign last_slot = (wr_cnt == AW'(DEPTH-1));
  // the first SERVE cycle may still see Valid left over from the previous run
  assign core_done = (state == ST_SERVE) && !serve_first && CORE_VALID;

  assign rd_idx    = AW'(CORE_W) * AW'(N) + AW'(CORE_J);
  assign CORE_COST = buf_q[rd_idx];

  assign CORE_RST  = core_rst_q;
  assign RES_VALID = res_vld_q;
  assign RES_COST  = res_q.cost;
  assign RES_MATCH = res_q.match;
  assign FRAME_ERR = frame_err_q;

  always_ff @(posedge CLK) begin
    if (!RST && accept) buf_q[wr_cnt] <= IN_DATA;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state       <= ST_LOAD;
      wr_cnt      <= '0;
      core_rst_q  <= 1'b1;
      serve_first <= 1'b0;
      res_vld_q   <= 1'b0;
      res_q       <= '0;
      frame_err_q <= 1'b0;
    end else begin
      case (state)
        ST_LOAD: begin
          if (accept) begin
            if (last_slot) begin
              wr_cnt      <= '0;
              state       <= ST_SERVE;
              core_rst_q  <= 1'b0;
              serve_first <= 1'b1;
              if (!IN_LAST) frame_err_q <= 1'b1;
            end else if (IN_LAST) begin
              // short frame: drop it and restart at index 0
              wr_cnt      <= '0;
              frame_err_q <= 1'b1;
            end else begin
              wr_cnt <= wr_cnt + AW'(1);
            end
          end
        end
        ST_SERVE: begin
          serve_first <= 1'b0;
          if (core_done) begin
            res_q.cost  <= CORE_MINCOST;
            res_q.match <= CORE_MATCH;
            res_vld_q   <= 1'b1;
            core_rst_q  <= 1'b1;
            state       <= ST_HOLD;
          end
        end
        ST_HOLD: begin
          if (RES_ACK) begin
            res_vld_q <= 1'b0;
            state     <= ST_LOAD;
          end
        end
        default: begin
          state      <= ST_LOAD;
          core_rst_q <= 1'b1;
        end
      endcase
    end
  end

`ifdef JAM_COST_CHECKSUM_EN
  logic [COST_W+5:0] chk_q;

  always_ff @(posedge CLK) begin
    if (RST) begin
      chk_q <= '0;
    end else if (accept) begin
      if (IN_LAST && !last_slot) chk_q <= '0;
      else                       chk_q <= chk_q + (COST_W+6)'(IN_DATA);
    end else if (state == ST_HOLD && RES_ACK) begin
      chk_q <= '0;
    end
  end

  assign CHKSUM = chk_q;
`endif

endmodule

// File: tb/tb_jam_cost_loader.sv
// Randomized directed bench for jam_cost_loader against a frame-level reference table.
module tb_jam_cost_loader;

  logic       CLK = 1'b0;
  logic       RST;
  logic       IN_VALID;
  logic       IN_READY;
  logic [6:0] IN_DATA;
  logic       IN_LAST;
  logic       CORE_RST;
  logic [2:0] CORE_W;
  logic [2:0] CORE_J;
  logic [6:0] CORE_COST;
  logic [9:0] CORE_MINCOST;
  logic [3:0] CORE_MATCH;
  logic       CORE_VALID;
  logic       RES_VALID;
  logic       RES_ACK;
  logic [9:0] RES_COST;
  logic [3:0] RES_MATCH;
  logic       FRAME_ERR;
`ifdef JAM_COST_CHECKSUM_EN
  logic [12:0] CHKSUM;
`endif

  jam_cost_loader dut (
    .CLK(CLK), .RST(RST),
    .IN_VALID(IN_VALID), .IN_READY(IN_READY), .IN_DATA(IN_DATA), .IN_LAST(IN_LAST),
    .CORE_RST(CORE_RST), .CORE_W(CORE_W), .CORE_J(CORE_J), .CORE_COST(CORE_COST),
    .CORE_MINCOST(CORE_MINCOST), .CORE_MATCH(CORE_MATCH), .CORE_VALID(CORE_VALID),
    .RES_VALID(RES_VALID), .RES_ACK(RES_ACK), .RES_COST(RES_COST), .RES_MATCH(RES_MATCH),
`ifdef JAM_COST_CHECKSUM_EN
    .CHKSUM(CHKSUM),
`endif
    .FRAME_ERR(FRAME_ERR)
  );

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;
  int frame   [64];
  int ref_tab [64];
  int ref_sum;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK); #1;
  endtask

  task automatic send(input int val, input bit last, input int maxgap);
    int g;
    g = (maxgap > 0) ? int'($urandom_range(maxgap, 0)) : 0;
    repeat (g) begin
      check("gap_ready", IN_READY, 1);
      check("gap_core_rst", CORE_RST, 1);
      step();
    end
    check("pre_ready", IN_READY, 1);
    IN_VALID = 1'b1; IN_DATA = val[6:0]; IN_LAST = last;
    step();
    IN_VALID = 1'b0; IN_LAST = 1'b0;
  endtask

  // streams frame[] and updates the reference only once the full frame is in
  task automatic load_frame(input int maxgap, input bit with_last, input bit exp_err);
    for (int i = 0; i < 63; i++) send(frame[i], 1'b0, maxgap);
    check("core_held_before_last", CORE_RST, 1);
    send(frame[63], with_last, maxgap);
    check("serve_ready_low", IN_READY, 0);
    check("serve_core_run", CORE_RST, 0);
    check("serve_frame_err", FRAME_ERR, exp_err);
    ref_sum = 0;
    for (int i = 0; i < 64; i++) begin
      ref_tab[i] = frame[i];
      ref_sum += frame[i];
    end
`ifdef JAM_COST_CHECKSUM_EN
    check("chksum", CHKSUM, ref_sum);
`endif
  endtask

  task automatic first_cycle_ignore();
    CORE_VALID = 1'b1; CORE_MINCOST = 10'($urandom); CORE_MATCH = 4'($urandom);
    step();
    CORE_VALID = 1'b0;
    check("first_serve_ignored", RES_VALID, 0);
    check("first_serve_core_run", CORE_RST, 0);
  endtask

  task automatic check_reads();
    for (int w = 0; w < 8; w++)
      for (int j = 0; j < 8; j++) begin
        CORE_W = w[2:0]; CORE_J = j[2:0];
        #0.1;
        check($sformatf("read_w%0d_j%0d", w, j), CORE_COST, ref_tab[w*8+j]);
      end
  endtask

  task automatic serve_result(input int mc, input int m, input int hold);
    CORE_MINCOST = mc[9:0]; CORE_MATCH = m[3:0]; CORE_VALID = 1'b1;
    step();
    CORE_VALID = 1'b0;
    check("res_valid", RES_VALID, 1);
    check("res_cost", RES_COST, mc);
    check("res_match", RES_MATCH, m);
    check("hold_core_rst", CORE_RST, 1);
    check("hold_ready", IN_READY, 0);
    repeat (hold) begin
      CORE_MINCOST = 10'($urandom); CORE_MATCH = 4'($urandom); CORE_VALID = 1'($urandom);
      step();
      check("hold_valid", RES_VALID, 1);
      check("hold_cost", RES_COST, mc);
      check("hold_match", RES_MATCH, m);
      check("hold_ready_stable", IN_READY, 0);
    end
    CORE_VALID = 1'b0;
    RES_ACK = 1'b1;
    step();
    RES_ACK = 1'b0;
    check("ack_valid_clr", RES_VALID, 0);
    check("ack_ready", IN_READY, 1);
    check("ack_core_rst", CORE_RST, 1);
`ifdef JAM_COST_CHECKSUM_EN
    check("ack_chksum_clr", CHKSUM, 0);
`endif
  endtask

  task automatic do_reset();
    RST = 1'b1;
    step(); step();
    check("rst_ready", IN_READY, 1);
    check("rst_core_rst", CORE_RST, 1);
    check("rst_res_valid", RES_VALID, 0);
    check("rst_res_cost", RES_COST, 0);
    check("rst_res_match", RES_MATCH, 0);
    check("rst_frame_err", FRAME_ERR, 0);
    RST = 1'b0;
  endtask

  task automatic rand_frame();
    for (int i = 0; i < 64; i++) frame[i] = int'($urandom_range(127, 0));
  endtask

  initial begin
    RST = 1'b1; IN_VALID = 0; IN_DATA = 0; IN_LAST = 0; CORE_W = 0; CORE_J = 0;
    CORE_MINCOST = 0; CORE_MATCH = 0; CORE_VALID = 0; RES_ACK = 0;
    do_reset();

    // (W+J)%8 pattern, back to back
    for (int i = 0; i < 64; i++) frame[i] = ((i / 8) + (i % 8)) % 8;
    load_frame(0, 1'b1, 1'b0);
    first_cycle_ignore();
    check_reads();
    serve_result(10'h1A5, 3, 5);

    // random data with random idle gaps; RES_ACK in LOAD must be ignored
    RES_ACK = 1'b1; step(); RES_ACK = 1'b0;
    check("ack_in_load_ready", IN_READY, 1);
    rand_frame();
    load_frame(3, 1'b1, 1'b0);
    first_cycle_ignore();
    RES_ACK = 1'b1; step(); RES_ACK = 1'b0;
    check("ack_in_serve_ready", IN_READY, 0);
    check("ack_in_serve_core", CORE_RST, 0);
    check_reads();
    serve_result(int'($urandom_range(1023, 0)), int'($urandom_range(15, 0)), 2);

    // early IN_LAST on entry 10 discards the partial frame
    for (int i = 0; i < 11; i++) send(int'($urandom_range(127, 0)), i == 10, 1);
    check("early_last_err", FRAME_ERR, 1);
    check("early_last_core_held", CORE_RST, 1);
    check("early_last_ready", IN_READY, 1);
    rand_frame();
    load_frame(1, 1'b1, 1'b1);
    first_cycle_ignore();
    check_reads();
    serve_result(int'($urandom_range(1023, 0)), int'($urandom_range(15, 0)), 1);

    // reset mid-SERVE, then a fresh run
    do_reset();
    rand_frame();
    load_frame(0, 1'b1, 1'b0);
    repeat (20) step();
    check("serve_20_core_run", CORE_RST, 0);
    RST = 1'b1;
    step();
    RST = 1'b0;
    check("midrst_ready", IN_READY, 1);
    check("midrst_core_rst", CORE_RST, 1);
    check("midrst_res_valid", RES_VALID, 0);
    rand_frame();
    load_frame(2, 1'b1, 1'b0);
    first_cycle_ignore();
    check_reads();
    serve_result(int'($urandom_range(1023, 0)), int'($urandom_range(15, 0)), 3);

    // full frame without IN_LAST is flagged yet still used
    rand_frame();
    load_frame(0, 1'b0, 1'b1);
    first_cycle_ignore();
    check_reads();
    serve_result(int'($urandom_range(1023, 0)), int'($urandom_range(15, 0)), 0);
    check("err_sticky", FRAME_ERR, 1);

`ifdef JAM_COST_CHECKSUM_EN
    do_reset();
    for (int i = 0; i < 64; i++) frame[i] = 127;
    load_frame(0, 1'b1, 1'b0);
    check("chksum_8128", CHKSUM, 8128);
    first_cycle_ignore();
    serve_result(1, 1, 1);
    for (int i = 0; i < 64; i++) frame[i] = 0;
    load_frame(0, 1'b1, 1'b0);
    check("chksum_zero", CHKSUM, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/jam_cost_loader.md
Name: jam_cost_loader

Overview:
- Upstream feeder for the 8x8 job-assignment core.
- Accepts one cost table per frame over a valid/ready stream and stores it in a 64-entry buffer.
- Holds the core in reset until the table is complete, then serves the core's (W,J) lookups combinationally.
- Captures the core's MinCost/MatchCount result and holds it behind a result handshake before accepting the next frame.

Parameters:
- N, 8, workers = jobs per table; table depth N*N; index width log2(N).
- COST_W, 7, bits per cost entry.
- SUM_W, 10, width of MinCost result.

Ports:
- CLK  in  1  clock; all state on posedge.
- RST  in  1  synchronous, active-high reset.
- IN_VALID  in  1  stream entry valid.
- IN_READY  out  1  loader accepts entry.
- IN_DATA  in  COST_W  cost entry, row-major: worker W, job J at index W*N+J.
- IN_LAST  in  1  marks final entry of frame.
- CORE_RST  out  1  reset to core; high = core held.
- CORE_W  in  log2(N)  worker index from core.
- CORE_J  in  log2(N)  job index from core.
- CORE_COST  out  COST_W  buffer[CORE_W*N+CORE_J], combinational.
- CORE_MINCOST  in  SUM_W  core result.
- CORE_MATCH  in  4  core match count.
- CORE_VALID  in  1  core result valid; level, driven on core negedge.
- RES_VALID  out  1  result held valid.
- RES_ACK  in  1  result consumed.
- RES_COST  out  SUM_W  captured MinCost.
- RES_MATCH  out  4  captured MatchCount.
- FRAME_ERR  out  1  sticky framing error.

Behaviour:
- Reset values: state=LOAD, wr_cnt=0, IN_READY=1, CORE_RST=1, RES_VALID=0, RES_COST=0, RES_MATCH=0, FRAME_ERR=0. Buffer contents are not reset.
- RST mid-operation aborts any frame or run and returns to LOAD with the core held.
- States: LOAD, SERVE, HOLD.

LOAD:
- IN_READY=1 and CORE_RST=1.
- An entry is accepted on IN_VALID&IN_READY: buffer[wr_cnt]<=IN_DATA, wr_cnt++ (6-bit for N=8).
- Early IN_LAST (IN_LAST=1 on an accepted entry with wr_cnt<N*N-1):
  - FRAME_ERR<=1.
  - wr_cnt<=0; the partial frame is discarded.
  - Stay in LOAD.
- Accepted entry with wr_cnt==N*N-1:
  - Go to SERVE next cycle; wr_cnt wraps to 0.
  - If IN_LAST=0, FRAME_ERR<=1 but the frame is still used.
- IN_VALID=0 stalls without side effects.

SERVE:
- IN_READY=0.
- CORE_RST=0 starting the first SERVE cycle (registered).
- CORE_COST is always a combinational read; it is valid in every state, with no latency, so the core can sample it on its negedge.
- CORE_VALID is ignored in the first SERVE cycle. This masks a stale core Valid from the previous run.
- From the second SERVE cycle, CORE_VALID=1 triggers:
  - RES_COST<=CORE_MINCOST, RES_MATCH<=CORE_MATCH, RES_VALID<=1.
  - CORE_RST<=1.
  - Go to HOLD.

HOLD:
- CORE_RST=1 and IN_READY=0.
- RES_VALID, RES_COST and RES_MATCH are held stable.
- RES_ACK=1 triggers: RES_VALID<=0, state<=LOAD, IN_READY=1 the next cycle.
- RES_ACK outside HOLD is ignored.

General rules:
- The minimum core-reset low-to-high spacing is ≥N*N cycles because LOAD takes ≥N*N cycles, which guarantees the core's Valid clears before SERVE.
- FRAME_ERR is cleared only by RST.

Optional Feature:
- Macro: JAM_COST_CHECKSUM_EN.
- When defined:
  - Adds output CHKSUM (COST_W+6 bits), the sum of all accepted entries of the current frame.
  - The accumulator clears to 0 on RST, on an early-IN_LAST discard, and on the LOAD entry from HOLD.
  - CHKSUM is held through SERVE/HOLD.
- When undefined: the port and accumulator are absent; all other behaviour is identical.

Test Plan:
- Stream 64 entries, value = (W+J)%8, with IN_LAST on entry 63 → IN_READY drops and CORE_RST falls the cycle after the 64th handshake. Every (W,J) read returns (W+J)%8. FRAME_ERR=0.
- Hold IN_VALID low between entries (random gaps) → wr_cnt advances only on handshakes. SERVE is entered only after the 64th accepted entry.
- Assert IN_LAST on entry 10 → FRAME_ERR=1, CORE_RST stays 1. A following clean 64-entry frame loads from index 0 and is served correctly.
- In SERVE, drive CORE_VALID=1, MINCOST=0x1A5, MATCH=3 → the next cycle shows RES_VALID=1, RES_COST=0x1A5, RES_MATCH=3, CORE_RST=1. Values are stable 5 cycles until RES_ACK; then IN_READY=1 one cycle later.
- Assert RST during SERVE after 20 cycles → the next cycle shows LOAD, CORE_RST=1, IN_READY=1, RES_VALID=0. A CORE_VALID pulse in the first SERVE cycle of the next run is ignored.
- With JAM_COST_CHECKSUM_EN, load 64 entries of value 127 → CHKSUM=8128. After ACK and a new frame of 64 zeros → CHKSUM=0.
